mux_81_16b: RTL and testbench

//   Registered 16-to-1 word multiplexer with enable. One of sixteen WIDTH-bit

---
 rtl/mux_81_16b_pkg.sv | 13 +
 rtl/mux_81_16b_mux_8to1.sv | 43 ++++
 rtl/mux_81_16b.sv | 76 +++++++
 tb/tb_mux_81_16b.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_81_16b_pkg.sv
// rtl/mux_81_16b_pkg.sv - shared sizing constants for the 16-to-1 registered word mux
//
// Purpose: lets the mux and any instantiating block agree on select width,
//          input count and default data width.
// Ports:   none (package).

package mux_81_16b_pkg;

  localparam int SEL_W  = 4;   // select index width
  localparam int NUM_IN = 16;  // number of data inputs
  localparam int DATA_W = 8;   // default data width (WIDTH)

endpackage : mux_81_16b_pkg

// File: rtl/mux_81_16b_mux_8to1.sv
// rtl/mux_81_16b_mux_8to1.sv - combinational 8-to-1 word selector
//
// Purpose: picks one of eight WIDTH-bit words by a 3-bit select.
// Ports:
//   i0..i7 in  WIDTH  data words
//   sel    in  3      select index (0 picks i0, 7 picks i7)
//   y      out WIDTH  selected word

module mux_8to1
  import mux_81_16b_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [SEL_W-2:0] sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] words [8];

  always_comb begin
    words[0] = i0;
    words[1] = i1;
    words[2] = i2;
    words[3] = i3;
    words[4] = i4;
    words[5] = i5;
    words[6] = i6;
    words[7] = i7;
  end

  // Array indexing (rather than a case with a default) lets an unknown
  // select propagate X in simulation instead of masking it.
  assign y = words[sel];

endmodule : mux_8to1

// File: rtl/mux_81_16b.sv
// rtl/mux_81_16b.sv - registered 16-to-1 word multiplexer with enable
//
// Purpose: registers c[a] to d on each rising clk edge when en is high,
//          registers zero when en is low. One-cycle latency.
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      asynchronous active-high reset, clears d
//   c0..c15 in  WIDTH  data inputs, c<k> selected when a == k
//   a       in  4      select index 0..15
//   en      in  1      1 = pass selected input, 0 = load zero
//   d       out WIDTH  registered selected data

module mux_81_16b
  import mux_81_16b_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] c0,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] c2,
  input  logic [WIDTH-1:0] c3,
  input  logic [WIDTH-1:0] c4,
  input  logic [WIDTH-1:0] c5,
  input  logic [WIDTH-1:0] c6,
  input  logic [WIDTH-1:0] c7,
  input  logic [WIDTH-1:0] c8,
  input  logic [WIDTH-1:0] c9,
  input  logic [WIDTH-1:0] c10,
  input  logic [WIDTH-1:0] c11,
  input  logic [WIDTH-1:0] c12,
  input  logic [WIDTH-1:0] c13,
  input  logic [WIDTH-1:0] c14,
  input  logic [WIDTH-1:0] c15,
  input  logic [SEL_W-1:0] a,
  input  logic             en,
  output logic [WIDTH-1:0] d
);

  logic [WIDTH-1:0] y_lo;
  logic [WIDTH-1:0] y_hi;
  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] d_q;

  // Low bank c0..c7 and high bank c8..c15 share a[2:0]; a[3] picks the bank.
  mux_8to1 #(.WIDTH(WIDTH)) u_mux_lo (
    .i0 (c0), .i1 (c1), .i2 (c2), .i3 (c3),
    .i4 (c4), .i5 (c5), .i6 (c6), .i7 (c7),
    .sel(a[SEL_W-2:0]),
    .y  (y_lo)
  );

  mux_8to1 #(.WIDTH(WIDTH)) u_mux_hi (
    .i0 (c8),  .i1 (c9),  .i2 (c10), .i3 (c11),
    .i4 (c12), .i5 (c13), .i6 (c14), .i7 (c15),
    .sel(a[SEL_W-2:0]),
    .y  (y_hi)
  );

  assign sel_d = a[SEL_W-1] ? y_hi : y_lo;
  assign d_d   = en ? sel_d : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

  // d comes straight from the flop so it never glitches between edges.
  assign d = d_q;

endmodule : mux_81_16b

// File: tb/tb_mux_81_16b.sv
// tb/tb_mux_81_16b.sv - self-checking bench for mux_81_16b

module tb_mux_81_16b;

  logic       clk;
  logic       rst;
  logic [7:0] c [16];
  logic [3:0] a;
  logic       en;
  logic [7:0] d;

  int checks;
  int failures;

  mux_81_16b #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .c0 (c[0]),  .c1 (c[1]),  .c2 (c[2]),  .c3 (c[3]),
    .c4 (c[4]),  .c5 (c[5]),  .c6 (c[6]),  .c7 (c[7]),
    .c8 (c[8]),  .c9 (c[9]),  .c10(c[10]), .c11(c[11]),
    .c12(c[12]), .c13(c[13]), .c14(c[14]), .c15(c[15]),
    .a  (a), .en(en), .d(d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_table();
    for (int k = 0; k < 16; k++) c[k] = 8'(k);
  endtask

  task automatic test_reset_state();
    rst = 1'b1; en = 1'b0; a = 4'd0;
    set_table();
    #2;
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL reset_state d=%h expected=%h", d, 8'h00);
    end
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    set_table();
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a = 4'(k);
      tick();
      checks++;
      if (d !== 8'(k)) begin
        failures++;
        $display("FAIL sweep a=%0d d=%h expected=%h", k, d, 8'(k));
      end
    end
  endtask

  task automatic test_reset_async();
    // d holds 0x0F from the sweep; assert rst mid-cycle.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL reset_async d=%h expected=%h", d, 8'h00);
    end
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold edge=%0d d=%h expected=%h", e, d, 8'h00);
      end
    end
    #2 rst = 1'b0;
    a = 4'd7;
    #1;
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL reset_release_preedge d=%h expected=%h", d, 8'h00);
    end
    tick();
    checks++;
    if (d !== 8'h07) begin
      failures++;
      $display("FAIL reset_release_load d=%h expected=%h", d, 8'h07);
    end
  endtask

  task automatic test_enable();
    set_table();
    c[5] = 8'hA5;
    a = 4'd5;
    en = 1'b0;
    tick();
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL enable_off d=%h expected=%h", d, 8'h00);
    end
    en = 1'b1;
    tick();
    checks++;
    if (d !== 8'hA5) begin
      failures++;
      $display("FAIL enable_on d=%h expected=%h", d, 8'hA5);
    end
  endtask

  task automatic test_boundary();
    for (int k = 0; k < 16; k++) c[k] = 8'h00;
    c[15] = 8'hFF;
    c[0]  = 8'h80;
    en = 1'b1;
    a = 4'd15;
    tick();
    checks++;
    if (d !== 8'hFF) begin
      failures++;
      $display("FAIL boundary_a15 d=%h expected=%h", d, 8'hFF);
    end
    a = 4'd0;
    tick();
    checks++;
    if (d !== 8'h80) begin
      failures++;
      $display("FAIL boundary_a0 d=%h expected=%h", d, 8'h80);
    end
    a = 4'd14;
    tick();
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL boundary_a14 d=%h expected=%h", d, 8'h00);
    end
    a = 4'd7;
    tick();
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL boundary_a7 d=%h expected=%h", d, 8'h00);
    end
  endtask

  task automatic test_latency_hold();
    set_table();
    en = 1'b1;
    a = 4'd3;
    tick();
    checks++;
    if (d !== 8'h03) begin
      failures++;
      $display("FAIL latency_first d=%h expected=%h", d, 8'h03);
    end
    #3 a = 4'd9;
    #1;
    checks++;
    if (d !== 8'h03) begin
      failures++;
      $display("FAIL latency_midcycle d=%h expected=%h", d, 8'h03);
    end
    tick();
    checks++;
    if (d !== 8'h09) begin
      failures++;
      $display("FAIL latency_update d=%h expected=%h", d, 8'h09);
    end
    tick();
    checks++;
    if (d !== 8'h09) begin
      failures++;
      $display("FAIL latency_hold d=%h expected=%h", d, 8'h09);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    int         bad;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 16; k++) c[k] = 8'($urandom);
      a   = 4'($urandom_range(0, 15));
      en  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 19) == 0);
      if (rst)     exp_d = 8'h00;
      else if (en) exp_d = c[a];
      else         exp_d = 8'h00;
      tick();
      checks++;
      if (d !== exp_d) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random n=%0d a=%0d en=%0b rst=%0b d=%h expected=%h",
                   n, a, en, rst, d, exp_d);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset_state();
    test_sweep();
    test_reset_async();
    test_enable();
    test_boundary();
    test_latency_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_81_16b
